// File: rtl/ahb_out_fifo.sv
// ---------------------------------------------------------------------------
// ahb_out_fifo
//   AHB-Lite slave output port. Software pushes words into a small FIFO via
//   the bus. A downstream consumer drains the head over a valid/ready
//   handshake. A write to a full FIFO either stalls the bus (STALL_ON_FULL=1)
//   or is dropped and sets a sticky overflow flag (STALL_ON_FULL=0).
//
//   Register map (HADDR[3:2]):
//     0  W: push HWDATA[DATA_WIDTH-1:0]   R: head entry (0 if empty, no pop)
//     1  R: {16'd0, count[7:0], 5'd0, OVF, full, DataValid}
//     2  W: bit0 flush, bit1 clear OVF    R: 0
//     3  R: 0
//
// Ports
//   HCLK, HRESETn     clock, asynchronous active-low reset
//   HADDR, HWDATA     address (only [3:2] decoded), write data
//   HSIZE             ignored (word transfers only)
//   HTRANS, HWRITE    transfer type (IDLE = 2'b00), direction
//   HREADY, HSEL      bus ready, slave select
//   HRDATA            read data, 0 outside a read data phase
//   HREADYOUT         low only while a push is stalled on a full FIFO
//   DataOut           FIFO head, 0 when empty
//   DataValid         FIFO not empty
//   DataReady         consumer accepts head on DataValid & DataReady
// ---------------------------------------------------------------------------
module ahb_out_fifo #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter bit          STALL_ON_FULL = 1'b1
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [31:0]           HADDR,
   input  logic [31:0]           HWDATA,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic                  HSEL,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  DataValid,
   input  logic                  DataReady
);

   localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_e;

   // Data-phase control captured in the address phase
   logic      write_en_q, write_en_d;
   logic      read_en_q,  read_en_d;
   reg_sel_e  addr_q,     addr_d;

   // FIFO state
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q,  count_d;
   logic                  ovf_q,    ovf_d;

   logic full;
   logic wr_data_ph;
   logic push;
   logic pop;
   logic ovf_evt;
   logic flush;
   logic clr_ovf;

   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

   assign full       = (count_q == FULL_CNT);
   assign DataValid  = (count_q != '0);
   assign wr_data_ph = write_en_q && (addr_q == REG_DATA);
   // full is a registered quantity, so a same-edge pop never rescues a write
   assign push       = wr_data_ph && !full;
   assign pop        = DataValid && DataReady;
   assign ovf_evt    = wr_data_ph && full && !STALL_ON_FULL;
   assign flush      = write_en_q && (addr_q == REG_CTRL) && HWDATA[0];
   assign clr_ovf    = write_en_q && (addr_q == REG_CTRL) && HWDATA[1];

   // Wait states only from registered state: no path from DataReady
   assign HREADYOUT  = !(STALL_ON_FULL && wr_data_ph && full);

   // Address phase capture; held while the bus is stalled
   always_comb begin
      write_en_d = write_en_q;
      read_en_d  = read_en_q;
      addr_d     = addr_q;
      if (HREADY) begin
         write_en_d = HSEL && (HTRANS != 2'b00) && HWRITE;
         read_en_d  = HSEL && (HTRANS != 2'b00) && !HWRITE;
         addr_d     = reg_sel_e'(HADDR[3:2]);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
      // overflow event beats a simultaneous clear
      if (ovf_evt)      ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         write_en_q <= 1'b0;
         read_en_q  <= 1'b0;
         addr_q     <= REG_DATA;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         write_en_q <= write_en_d;
         read_en_q  <= read_en_d;
         addr_q     <= addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage needs no reset: contents are only visible when count is nonzero
   always_ff @(posedge HCLK) begin
      if (push) mem_q[wr_ptr_q] <= HWDATA[DATA_WIDTH-1:0];
   end

   always_comb begin
      DataOut = '0;
      if (DataValid) DataOut = mem_q[rd_ptr_q];
   end

   always_comb begin
      HRDATA = '0;
      if (read_en_q) begin
         case (addr_q)
            REG_DATA:   HRDATA = 32'(DataOut);
            REG_STATUS: HRDATA = {16'd0, 8'(count_q), 5'd0, ovf_q, full, DataValid};
            default:    HRDATA = '0;
         endcase
      end
   end

endmodule
